relu1_stream_reader: RTL and testbench

//  Read side of the layer-1 activation buffer. On start, sweeps addresses 0..DEPTH-1,

---
 rtl/relu1_stream_reader.sv | 127 ++++++++++++
 tb/tb_relu1_stream_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/relu1_stream_reader.sv
// relu1_stream_reader: read side of the layer-1 activation buffer.
// It sweeps addresses 0..DEPTH-1 and absorbs the buffer's 1-cycle registered
// read latency. Each activation is presented on a valid/ready stream, and a
// 2-entry skid FIFO holds reads that are still in flight during a stall.
// Optional macro RELU1_READER_CLAMP_EN clamps negative activations to zero
// as they enter the FIFO.
module relu1_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;          // next address to issue
  logic [ADDR_WIDTH-1:0] addr_hold_q;     // last issued address, held when idle
  logic                  inflight_q;      // a read returns data this cycle
  logic [ADDR_WIDTH-1:0] inflight_idx_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [ADDR_WIDTH-1:0] fifo_idx_q  [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  issue, push, pop;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] push_data;

  assign pop  = out_valid & out_ready;
  assign push = inflight_q;
  assign occ  = count_q + {1'b0, inflight_q};
  // A pop this cycle frees a slot for the read issued now. This keeps
  // throughput at one element per cycle while the FIFO can never overflow.
  assign issue = (state_q == S_RUN) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  assign mem_read_addr = issue ? addr_q : addr_hold_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_index = fifo_idx_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];

  // Sweep sequencing: issue all addresses, drain the FIFO, then pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Value pushed into the FIFO, optionally re-applying ReLU.
  always_comb begin
    push_data = mem_data_in;
`ifdef RELU1_READER_CLAMP_EN
    if (mem_data_in[DATA_WIDTH-1]) push_data = '0;
`endif
  end

  // State, address counter and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      addr_hold_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (state_q == S_IDLE) begin
        addr_q <= '0;
      end else if (issue) begin
        addr_q         <= addr_q + 1'b1;
        addr_hold_q    <= addr_q;
        inflight_idx_q <= addr_q;
      end
    end
  end

  // 2-entry skid FIFO. Push and pop in the same cycle are allowed, even when the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        fifo_last_q[wr_ptr_q] <= (inflight_idx_q == LAST_ADDR);
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_relu1_stream_reader.sv
// Directed bench for relu1_stream_reader with a registered-read buffer model.
module tb_relu1_stream_reader;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, out_last, out_valid;
  logic [AW-1:0] mem_read_addr, out_index;
  logic [DW-1:0] mem_data_in = '0;
  logic [DW-1:0] out_data;

  relu1_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_read_addr(mem_read_addr), .mem_data_in(mem_data_in),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [DEPTH];
  always @(posedge clk) mem_data_in <= mem[mem_read_addr[5:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_idx, dones, first_cyc, done_cyc, start_cyc;
  logic prev_stall, last_prev;
  logic [DW-1:0] pd;
  logic [AW-1:0] pi;
  logic pl;
  logic [DW-1:0] got [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] expv(input int i);
    logic signed [DW-1:0] v;
    v = mem[i];
`ifdef RELU1_READER_CLAMP_EN
    if (v < 0) v = '0;
`endif
    return v;
  endfunction

  task automatic chk_all_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", mem_read_addr, 0);
  endtask

  // One clock: drive at negedge, sample just after, score any transfer.
  task automatic cycle(input logic st, input logic rdy);
    @(negedge clk);
    start = st;
    out_ready = rdy;
    #1;
    cyc++;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pd);
      chk("hold_index", out_index, pi);
      chk("hold_last", out_last, pl);
    end
    if (last_prev) chk("done_after_last", done, 1);
    else if (done) chk("done_unexpected", done, 0);
    if (done) begin dones++; done_cyc = cyc; end
    chk("addr_range", mem_read_addr < DEPTH, 1);
    chk("occupancy", dut.count_q <= 2, 1);
    last_prev = 1'b0;
    if (out_valid && out_ready) begin
      if (first_cyc < 0) first_cyc = cyc;
      if (exp_idx < DEPTH) begin
        chk("data", out_data, expv(exp_idx));
        chk("index", out_index, exp_idx);
        chk("last", out_last, exp_idx == DEPTH - 1);
        got[exp_idx] = out_data;
        last_prev = (exp_idx == DEPTH - 1);
      end else begin
        chk("extra_transfer", exp_idx, DEPTH - 1);
      end
      exp_idx++;
    end
    $display("cyc=%0d valid=%0b ready=%0b idx=%0d data=%0h last=%0b done=%0b addr=%0d",
             cyc, out_valid, out_ready, out_index, out_data, out_last, done, mem_read_addr);
    prev_stall = out_valid && !out_ready;
    pd = out_data; pi = out_index; pl = out_last;
  endtask

  // mode 0: ready=1; mode 1: fixed ready pattern; mode 2: ready=0 for 20 cycles.
  task automatic sweep(input int mode, input int poke_idx, input int abort_idx);
    int post;
    logic rdy, st;
    bit poked;
    logic [31:0] pat;
    pat = 32'hB5C3_96E1;
    post = 0; poked = 0;
    exp_idx = 0; dones = 0; first_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0; last_prev = 1'b0;
    cycle(1'b1, (mode == 2) ? 1'b0 : 1'b1);
    start_cyc = cyc;
    for (int n = 1; n < 600; n++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[n % 32];
        default: rdy = (n > 20);
      endcase
      st = 1'b0;
      if (poke_idx >= 0 && exp_idx == poke_idx && !poked) begin st = 1'b1; poked = 1; end
      cycle(st, rdy);
      if (n == 1) begin
        chk("busy_after_start", busy, 1);
        chk("valid_too_early", out_valid, 0);
      end
      if (mode == 2 && n == 20) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", mem_read_addr, 1);
        chk("stall_index", out_index, 0);
        chk("stall_data", out_data, expv(0));
      end
      if (abort_idx >= 0 && exp_idx == abort_idx) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_stall = 1'b0;
        last_prev = 1'b0;
        return;
      end
      if (dones > 0) begin
        post++;
        if (post > 3) break;
      end
    end
    chk("transfers", exp_idx, DEPTH);
    chk("done_pulses", dones, 1);
    chk("busy_after_sweep", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3 - 10);
    #12;
    chk_all_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate sweep with latency checks.
    sweep(0, -1, -1);
    chk("first_valid_latency", first_cyc - start_cyc, 3);
    chk("done_latency", done_cyc - start_cyc, DEPTH + 3);

    // Irregular backpressure.
    sweep(1, -1, -1);

    // Long initial stall, then release.
    sweep(2, -1, -1);

    // start pulsed mid-sweep must be ignored.
    sweep(0, 30, -1);

    // Reset at element 40, then a clean sweep.
    sweep(0, -1, 40);
    chk("busy_after_abort", busy, 0);
    sweep(0, -1, -1);

    // Negative element 5.
    mem[5] = -7;
    sweep(0, -1, -1);
`ifdef RELU1_READER_CLAMP_EN
    chk("elem5_value", got[5], 32'h0000_0000);
`else
    chk("elem5_value", got[5], 32'hFFFF_FFF9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
